morse_encoder: RTL

//   Transmit side of the Morse path. Accepts one character as a dot/dash pattern over a valid/ready handshake.

---
 rtl/morse_encoder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/morse_encoder.sv
// morse_encoder
//   Transmit side of the Morse path. Takes one character as a dot/dash
//   pattern over a valid/ready handshake and keys it out with standard
//   Morse timing. The timing comes from a prescaler that counts clock
//   cycles per Morse unit.
//
//   Parameters
//     UNIT_CYCLES  clock cycles per Morse time unit (>= 1)
//     MAX_SYMS     maximum dots/dashes per character (<= 7)
//
//   Ports
//     CLK         system clock; all logic runs on its rising edge
//     RST         synchronous, active-high reset
//     in_valid    a character is presented on in_len / in_pattern
//     in_ready    encoder is idle and can accept a character this cycle
//     in_len      symbol count 0..MAX_SYMS; 0 means word space; larger values clamp
//     in_pattern  bit i is symbol i, sent LSB first (1 = dash, 0 = dot)
//     key_out     1 = mark (tone/LED on), 0 = space
//     busy        inverse of in_ready
//     done        one-cycle pulse when a character, including its gap, finishes
module morse_encoder #(
  parameter int UNIT_CYCLES = 25,
  parameter int MAX_SYMS    = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_len,
  input  logic [MAX_SYMS-1:0] in_pattern,
  output logic                key_out,
  output logic                busy,
  output logic                done
);

  localparam int              CW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0]   CYC_LAST = CW'(UNIT_CYCLES - 1);
  localparam logic [2:0]      LEN_MAX  = 3'(MAX_SYMS);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    CGAP,
    WGAP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [2:0]            unit_q, unit_d;
  logic [2:0]            sym_q, sym_d;
  logic [2:0]            len_q, len_d;
  logic [MAX_SYMS-1:0]   pat_q, pat_d;
  logic                  done_q, done_d;

  logic                  is_dash;
  logic                  unit_end;
  logic                  phase_end;
  logic [2:0]            unit_last;

  // The current symbol is selected with a mask rather than an index, so an
  // index past MAX_SYMS simply reads as a dot.
  assign is_dash  = |(pat_q & (MAX_SYMS'(1) << sym_q));
  assign unit_end = (cyc_q == CYC_LAST);

  // unit_last holds the index of the final unit in the current phase. The
  // phase ends when that unit's last cycle is reached.
  always_comb begin
    unit_last = 3'd0;
    case (state_q)
      MARK:    unit_last = is_dash ? 3'd2 : 3'd0;
      SPACE:   unit_last = 3'd0;
      CGAP:    unit_last = 3'd2;
      WGAP:    unit_last = 3'd6;
      default: unit_last = 3'd0;
    endcase
  end

  assign phase_end = unit_end && (unit_q == unit_last);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    sym_d   = sym_q;
    len_d   = len_q;
    pat_d   = pat_q;
    done_d  = 1'b0;

    // The prescaler free-runs in every active state. A phase change
    // overrides it below.
    if (state_q != IDLE) begin
      if (unit_end) begin
        cyc_d  = '0;
        unit_d = unit_q + 3'd1;
      end else begin
        cyc_d  = cyc_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          len_d   = (in_len > LEN_MAX) ? LEN_MAX : in_len;
          pat_d   = in_pattern;
          sym_d   = 3'd0;
          cyc_d   = '0;
          unit_d  = 3'd0;
          state_d = (in_len == 3'd0) ? WGAP : MARK;
        end
      end
      MARK: begin
        if (phase_end) begin
          cyc_d  = '0;
          unit_d = 3'd0;
          if ((sym_q + 3'd1) < len_q) begin
            sym_d   = sym_q + 3'd1;
            state_d = SPACE;
          end else begin
            state_d = CGAP;
          end
        end
      end
      SPACE: begin
        if (phase_end) begin
          cyc_d   = '0;
          unit_d  = 3'd0;
          state_d = MARK;
        end
      end
      CGAP, WGAP: begin
        if (phase_end) begin
          cyc_d   = '0;
          unit_d  = 3'd0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= 3'd0;
      sym_q   <= 3'd0;
      len_q   <= 3'd0;
      pat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
    end
  end

  // The done cycle is also an IDLE cycle. This lets characters run
  // back to back with no extra idle cycle between them.
  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign key_out  = (state_q == MARK);
  assign done     = done_q;

endmodule
